// File: rtl/seq_div_32.sv
// seq_div_32: 32-bit sequential restoring divider.
//
// Takes one quotient bit per cycle, so a division takes 32 CALC cycles.
// A divisor of zero skips CALC and reports Q=all-ones, R=A, DIV_ZERO=1.
//
// Optional feature: define SEQ_DIV_SIGNED_EN to enable two's-complement
// division when SIGNED=1. Operands are divided as magnitudes, Q is negated
// when the operand signs differ and R takes the sign of A. Without the
// macro SIGNED is ignored and no sign-correction logic is built.
//
// Ports:
//   CLK      in   1  rising-edge clock
//   RST      in   1  asynchronous active-low reset
//   START    in   1  request, accepted when BUSY=0
//   A        in  32  dividend, latched on accepted START
//   B        in  32  divisor, latched on accepted START
//   SIGNED   in   1  1 = signed divide (SEQ_DIV_SIGNED_EN builds only)
//   Q        out 32  quotient
//   R        out 32  remainder
//   BUSY     out  1  high while in CALC
//   DONE     out  1  one-cycle pulse when Q/R become valid
//   DIV_ZERO out  1  divisor was zero for the held result
module seq_div_32 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SIGNED,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIV_ZERO
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits in
  logic [31:0] rem_q, rem_d;   // partial remainder
  logic [31:0] dvs_q, dvs_d;   // divisor (magnitude in signed mode)
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;

  logic [31:0] a_op, b_op;
  logic [31:0] q_fin, r_fin;

  // One restoring step
  logic [32:0] rem_shift;
  logic [31:0] sub;
  logic        take;
  logic [31:0] rem_next, quo_next;

  assign rem_shift = {rem_q, quo_q[31]};
  assign take      = (rem_shift >= {1'b0, dvs_q});
  // When take is set the true difference is below the divisor, so 32 bits are exact.
  assign sub       = rem_shift[31:0] - dvs_q;
  assign rem_next  = take ? sub : rem_shift[31:0];
  assign quo_next  = {quo_q[30:0], take};

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign a_op   = (SIGNED && A[31]) ? -A : A;
  assign b_op   = (SIGNED && B[31]) ? -B : B;
  assign qneg_d = SIGNED && (A[31] ^ B[31]);
  assign rneg_d = SIGNED && A[31];
  assign q_fin  = qneg_q ? -quo_next : quo_next;
  assign r_fin  = rneg_q ? -rem_next : rem_next;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (START && (state_q != StCalc)) begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = SIGNED;
  assign a_op          = A;
  assign b_op          = B;
  assign q_fin         = quo_next;
  assign r_fin         = rem_next;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle, StFin: begin
        if (START) begin
          cnt_d = 5'd0;
          if (B == 32'd0) begin
            state_d = StFin;
            q_d     = 32'hFFFF_FFFF;
            r_d     = A;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = StCalc;
            quo_d   = a_op;
            rem_d   = 32'd0;
            dvs_d   = b_op;
          end
        end else if (state_q == StFin) begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 5'd1;
        quo_d = quo_next;
        rem_d = rem_next;
        if (cnt_q == 5'd31) begin
          state_d = StFin;
          q_d     = q_fin;
          r_d     = r_fin;
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign BUSY     = (state_q == StCalc);
  assign DONE     = done_q;
  assign DIV_ZERO = dz_q;

endmodule

// File: tb/tb_seq_div_32.sv
// tb_seq_div_32: directed and random checks of seq_div_32 against an
// arithmetic reference model (plain / and % on the operands).
module tb_seq_div_32;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] A;
  logic [31:0] B;
  logic        SIGNED;
  logic [31:0] Q;
  logic [31:0] R;
  logic        BUSY;
  logic        DONE;
  logic        DIV_ZERO;

  int n_assert = 0;
  int n_fail   = 0;

  seq_div_32 dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .A        (A),
    .B        (B),
    .SIGNED   (SIGNED),
    .Q        (Q),
    .R        (R),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DIV_ZERO (DIV_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: divide-by-zero rule, else 64-bit arithmetic (no overflow at MIN/-1).
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
      q  = a / b;
      r  = a % b;
`ifdef SEQ_DIV_SIGNED_EN
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        q  = sq[31:0];
        r  = sr[31:0];
      end
`else
      sa = longint'(s);
      sb = sa;
      sq = sb;
      sr = sq;
`endif
    end
  endfunction

  // Count cycles from the current point until DONE, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (DONE !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    logic [31:0] eq, er;
    logic        edz;
    int          lat;
    model(a, b, s, eq, er, edz);
    A      = a;
    B      = b;
    SIGNED = s;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    check({tag, ".busy"}, BUSY, (b != 32'd0));
    wait_done(lat);
    check({tag, ".lat"}, lat, (b == 32'd0) ? 0 : 32);
    check({tag, ".q"}, Q, eq);
    check({tag, ".r"}, R, er);
    check({tag, ".dz"}, DIV_ZERO, edz);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] hq, hr;
    logic [31:0] ra, rb;
    logic        rs;

    RST    = 1'b1;
    START  = 1'b0;
    A      = 32'd0;
    B      = 32'd0;
    SIGNED = 1'b0;
    #1 RST = 1'b0;
    #2;
    check("rst.q", Q, 0);
    check("rst.r", R, 0);
    check("rst.busy", BUSY, 0);
    check("rst.done", DONE, 0);
    check("rst.dz", DIV_ZERO, 0);
    repeat (2) tick();
    RST = 1'b1;

    do_op("u100_7", 32'd100, 32'd7, 1'b0);
    check("u100_7.q_const", Q, 32'd14);
    check("u100_7.r_const", R, 32'd2);
    // Result holds with DONE as a single pulse
    hq = Q;
    hr = R;
    tick();
    check("hold.done", DONE, 0);
    repeat (3) tick();
    check("hold.q", Q, hq);
    check("hold.r", R, hr);
    check("hold.busy", BUSY, 0);

    do_op("dz", 32'h1234_5678, 32'd0, 1'b0);
    tick();
    check("dz.done_pulse", DONE, 0);
    check("dz.held", DIV_ZERO, 1);

    do_op("max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op("5_9", 32'd5, 32'd9, 1'b0);
    check("5_9.q_const", Q, 32'd0);
    do_op("neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op("sdz", 32'h8765_4321, 32'd0, 1'b1);

    // START during CALC is ignored; START in the DONE cycle is accepted
    A     = 32'd50;
    B     = 32'd5;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (9) tick();
    A     = 32'd9;
    B     = 32'd3;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("proto.busy", BUSY, 1);
    wait_done(lat);
    check("proto.lat", lat, 22);
    check("proto.q", Q, 32'd10);
    check("proto.r", R, 32'd0);
    A     = 32'd81;
    B     = 32'd9;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("b2b.done", DONE, 0);
    check("b2b.busy", BUSY, 1);
    wait_done(lat);
    check("b2b.lat", lat, 32);
    check("b2b.q", Q, 32'd9);
    check("b2b.r", R, 32'd0);

    // Reset in the middle of CALC
    A     = 32'd1000;
    B     = 32'd3;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (14) tick();
    #2 RST = 1'b0;
    #1;
    check("mid.q", Q, 0);
    check("mid.r", R, 0);
    check("mid.busy", BUSY, 0);
    check("mid.done", DONE, 0);
    check("mid.dz", DIV_ZERO, 0);
    repeat (3) tick();
    RST  = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (DONE === 1'b1) seen++;
    end
    check("mid.no_done", seen, 0);
    do_op("after_rst", 32'd1000, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom_range(1, 15);
        1: rb = $urandom;
        2: rb = ra >> $urandom_range(0, 31);
        default: rb = (i % 8 == 7) ? 32'd0 : $urandom_range(1, 65535);
      endcase
      rs = 1'($urandom_range(0, 1));
      do_op("rand", ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_div_32.md
SEQ_DIV_32 -- requirements
Module: seq_div_32

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset: CLK  input  1  rising-edge clock.
REQ-003 The block SHALL provide RST  input  1  asynchronous active-low reset.
REQ-004 The block SHALL provide START  input  1  request; sampled on CLK rise when BUSY=0.
REQ-005 The block SHALL provide A  input  32  dividend, latched with an accepted START.
REQ-006 The block SHALL provide B  input  32  divisor, latched with an accepted START.
REQ-007 The block SHALL provide SIGNED  input  1  1 = two's-complement divide (see Configuration).
REQ-008 The block SHALL provide Q  output  32  quotient.
REQ-009 The block SHALL provide R  output  32  remainder.
REQ-010 The block SHALL provide BUSY  output  1  high while a division is in progress.
REQ-011 The block SHALL provide DONE  output  1  one-cycle pulse when Q/R become valid.
REQ-012 The block SHALL provide DIV_ZERO  output  1  B was zero for the current result, valid with DONE and held with Q/R.

Function
REQ-013 The block SHALL implement states IDLE, CALC and FIN.
REQ-014 In IDLE or FIN, a START=1 sampled on CLK rise SHALL latch A, B and SIGNED, clear the iteration counter and enter CALC; BUSY SHALL be high the following cycle.
REQ-015 START SHALL be ignored while BUSY=1; latched operands SHALL NOT change.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle: shift the partial remainder left by 1, bring in the next dividend MSB, subtract the divisor, restore when the result is negative, and shift the quotient bit in.
REQ-017 CALC SHALL last exactly 32 cycles; the edge completing step 32 SHALL enter FIN.
REQ-018 With START accepted on edge N, DONE SHALL be high for exactly the cycle following edge N+32 and Q/R SHALL be valid in that cycle.
REQ-019 Q, R and DIV_ZERO SHALL hold their values from DONE until the next START is accepted.
REQ-020 FIN SHALL return to IDLE on the next edge if START=0; a START in FIN SHALL be accepted (back-to-back operation).
REQ-021 If B=0 at START, the block SHALL skip CALC and enter FIN on the next edge with Q=32'hFFFFFFFF, R=A and DIV_ZERO=1; DONE SHALL follow after 1 cycle, not 33.
REQ-022 Unsigned arithmetic SHALL satisfy A = Q*B + R with R < B.
REQ-023 BUSY SHALL be high in CALC only, and DONE SHALL be high in the first FIN cycle only.

Reset
REQ-024 RST=0 SHALL immediately force IDLE, with Q=0, R=0, BUSY=0, DONE=0, DIV_ZERO=0 and the counter at 0, regardless of CLK.
REQ-025 Reset during CALC SHALL abort the division; no DONE SHALL be produced for that operation.
REQ-026 The first START SHALL be accepted on the first CLK rise after RST deasserts.

Configuration
REQ-027 The macro SEQ_DIV_SIGNED_EN SHALL control signed support.
REQ-028 With SEQ_DIV_SIGNED_EN defined and SIGNED=1, operands SHALL be divided as magnitudes; Q SHALL be negated when A[31]^B[31]=1 and R SHALL take the sign of A.
REQ-029 With SEQ_DIV_SIGNED_EN defined, 32'h80000000 / 32'hFFFFFFFF SHALL yield Q=32'h80000000 and R=0 with normal latency.
REQ-030 With SEQ_DIV_SIGNED_EN defined, signed divide-by-zero SHALL follow REQ-021.
REQ-031 Without SEQ_DIV_SIGNED_EN, SIGNED SHALL be ignored, all divisions SHALL be unsigned, and no sign-correction logic SHALL be synthesised.

Verification
REQ-032 Unsigned: A=100, B=7, START on edge N -> DONE in the cycle after edge N+32, Q=14, R=2, DIV_ZERO=0.
REQ-033 Divide by zero: A=32'h12345678, B=0 -> DONE one cycle after acceptance, Q=32'hFFFFFFFF, R=32'h12345678, DIV_ZERO=1.
REQ-034 Extremes: A=32'hFFFFFFFF, B=1 -> Q=32'hFFFFFFFF, R=0; then A=5, B=9 -> Q=0, R=5.
REQ-035 Signed (macro defined): A=-7, B=2, SIGNED=1 -> Q=32'hFFFFFFFD, R=32'hFFFFFFFF; the same stimulus without the macro -> Q=32'h7FFFFFFC, R=1.
REQ-036 Protocol: START with A=50, B=5, then a second START at cycle 10 with A=9, B=3 -> the second START is ignored, result Q=10, R=0; a START in the DONE cycle is accepted back-to-back.
REQ-037 Reset mid-op: RST=0 at cycle 15 of CALC -> outputs go to 0 immediately and no DONE occurs; the next START after release completes normally.
